cam_capture_param: RTL and testbench
====================================

Name: cam_capture_param

Overview:
- Next-generation camera capture block for OV7670-class sensors; runs entirely in the pixel clock domain.
- Converts the 8-bit DVP byte stream (vsync/href/data) into 24-bit RGB888 pixel writes with linear frame-buffer addresses.
- Generalises the fixed capture path:
  - run-time pixel format (RGB565 / RGB444 / YUV422-luma);
  - run-time decimation (1, 1/2, 1/4);
  - parametrised resolution;
  - frame gating, frame counter, and line/overflow error reporting.

Parameters:
- H_RES, 640, active pixels per sensor line
- V_RES, 480, active lines per frame
- ADDR_W, 19, write-address width; must satisfy 2^ADDR_W >= H_RES*V_RES
- FCNT_W, 8, frame counter width

Ports:
- ipclk  in  1  pixel clock, single clock for the whole block
- ireset_n  in  1  asynchronous active-low reset
- ivsync  in  1  sensor vsync, high during vertical blanking
- ihref  in  1  sensor href, high during active line bytes
- idata  in  8  sensor byte
- ienable  in  1  capture enable, sampled only at frame start
- imode  in  2  pixel format: 0 RGB565, 1 RGB444 (xRGB), 2 YUV422 luma, 3 reserved (treated as RGB565)
- idecim  in  2  decimation: 0 none, 1 /2, 2 /4, 3 treated as /4
- owr_en  out  1  one-cycle pixel write strobe
- oaddr  out  ADDR_W  pixel address, valid with owr_en
- odata_out  out  24  RGB888 pixel, valid with owr_en
- oframe_start  out  1  one-cycle pulse at start of a captured frame
- oframe_done  out  1  one-cycle pulse at end of a captured frame
- oframe_cnt  out  FCNT_W  count of completed captured frames, wraps
- oline_err  out  1  sticky: line length mismatch or odd byte count; cleared at next oframe_start
- oovf  out  1  sticky: write suppressed past frame end; cleared at next oframe_start

Behaviour:
- Reset: all outputs 0; FSM to WAIT_VS; counters 0. Asserting ireset_n low mid-frame aborts the frame with no further writes; capture resumes at the next vsync falling edge.
- Input registering: ivsync, ihref and idata registered once; all decisions use the registered values plus a registered previous vsync/href for edge detection.
- FSM WAIT_VS: wait for vsync falling edge.
  - If ienable=1: latch imode and idecim (mode/decim stay fixed for the frame), clear address, x/y counters and sticky errors, pulse oframe_start, go to ACTIVE.
  - Else: stay in WAIT_VS.
- FSM ACTIVE:
  - Bytes are taken only while href=1; a byte-phase bit toggles per byte and resets at each href rising edge.
  - Phase 0 byte is held; the phase 1 byte completes the pixel.
  - vsync rising edge: pulse oframe_done, increment oframe_cnt, go to WAIT_VS.
  - Deasserting ienable mid-frame has no effect until frame end.
- Conversion, with b0 = first byte and b1 = second byte:
  - RGB565: R5=b0[7:3], G6={b0[2:0],b1[7:5]}, B5=b1[4:0]; expand by MSB replication, e.g. R8={R5,R5[4:2]}.
  - RGB444: R4=b0[3:0], G4=b1[7:4], B4=b1[3:0]; R8={R4,R4}, and likewise for G and B.
  - YUV422 luma: Y=b0; output {Y,Y,Y}.
- Decimation, with d = latched decim (0/1/2):
  - Pixel x is kept iff x[d-1:0]==0; line y is kept iff y[d-1:0]==0.
  - x counts sensor pixels per line, y counts lines; both reset at frame start, x also at href rise.
- Address: running count of kept pixels, starting at 0 each frame. Max valid = (H_RES>>d)*(V_RES>>d)-1.
  - A kept pixel at an address beyond max is not written (owr_en stays 0), oovf is set, and the address does not advance.
- Latency: owr_en, oaddr and odata_out valid exactly 2 ipclk after the phase 1 byte is present on idata. owr_en is high for one cycle.
- Line check at href falling edge:
  - If byte phase = 1 (odd byte count), the dangling byte is discarded and oline_err is set.
  - If pixel count != H_RES, oline_err is set.
  - y increments at every href falling edge regardless.
- Simultaneous events: vsync rising in the same cycle as a final pixel still produces that write; oframe_done is then asserted in the same cycle as or after that owr_en, never before it.
- oframe_cnt increments only for frames that produced oframe_start.

Decomposition:
- Shared package cam_pkg:
  - typedef enum pix_fmt_t {PF_RGB565, PF_RGB444, PF_YUV_Y};
  - typedef enum decim_t;
  - typedef enum cap_state_t {WAIT_VS, ACTIVE};
  - default H_RES/V_RES constants.
- One sub-module, cam_pix_convert: registered format converter taking (fmt, b0, b1, valid) and producing (rgb888, valid), 1-cycle latency. It is the second pipeline stage.

Test Plan:
- RGB565, decim 0, 4x2 test frame (H_RES=4, V_RES=2), pixel bytes 0xF8,0x00 -> 8 writes at addr 0..7, data 0xFF0000; one oframe_start, one oframe_done; oframe_cnt=1.
- RGB444, bytes 0x0A,0x5F -> data 0xAA55FF. YUV luma, bytes 0x80,0x33 -> data 0x808080.
- Decim 1 on a 4x4 frame -> 4 writes at addr 0..3, taken from sensor pixels (0,0),(2,0),(0,2),(2,2).
- Line with 3 pixels plus one odd byte -> 3 writes, oline_err=1 until next frame start, then 0.
- 9 pixels into a 4x2 frame -> 8 writes, no write at addr 8, oovf=1.
- ienable=0 at vsync fall -> no writes, no pulses. ireset_n low mid-line -> all outputs 0 immediately; next frame captured normally from addr 0.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and defaults for the DVP camera capture path.
package cam_pkg;
    localparam int DEF_H_RES = 640;
    localparam int DEF_V_RES = 480;

    typedef enum logic [1:0] {
        PF_RGB565 = 2'd0,
        PF_RGB444 = 2'd1,
        PF_YUV_Y  = 2'd2
    } pix_fmt_t;

    typedef enum logic [1:0] {
        DEC_1 = 2'd0,
        DEC_2 = 2'd1,
        DEC_4 = 2'd2
    } decim_t;

    typedef enum logic {
        WAIT_VS = 1'b0,
        ACTIVE  = 1'b1
    } cap_state_t;

    // Reserved encodings fold onto the nearest meaningful setting.
    function automatic pix_fmt_t decode_fmt(input logic [1:0] m);
        pix_fmt_t f;
        case (m)
            2'd1:    f = PF_RGB444;
            2'd2:    f = PF_YUV_Y;
            default: f = PF_RGB565;
        endcase
        return f;
    endfunction

    function automatic decim_t decode_decim(input logic [1:0] d);
        decim_t r;
        case (d)
            2'd0:    r = DEC_1;
            2'd1:    r = DEC_2;
            default: r = DEC_4;
        endcase
        return r;
    endfunction
endpackage

// File: rtl/cam_pix_convert.sv
// Second pipeline stage: turns a two-byte sensor pixel into registered RGB888.
module cam_pix_convert
    import cam_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  pix_fmt_t    i_fmt,
    input  logic [7:0]  i_b0,
    input  logic [7:0]  i_b1,
    input  logic        i_valid,
    output logic [23:0] o_rgb,
    output logic        o_valid
);
    logic [4:0]  w_r5;
    logic [5:0]  w_g6;
    logic [4:0]  w_b5;
    logic [23:0] w_rgb;
    logic [23:0] r_rgb;
    logic        r_valid;

    assign w_r5 = i_b0[7:3];
    assign w_g6 = {i_b0[2:0], i_b1[7:5]};
    assign w_b5 = i_b1[4:0];

    // Channels are widened by replicating their MSBs so full scale maps to 0xFF.
    always_comb begin
        w_rgb = {w_r5, w_r5[4:2], w_g6, w_g6[5:4], w_b5, w_b5[4:2]};
        case (i_fmt)
            PF_RGB444: w_rgb = {i_b0[3:0], i_b0[3:0], i_b1[7:4], i_b1[7:4],
                                i_b1[3:0], i_b1[3:0]};
            PF_YUV_Y:  w_rgb = {i_b0, i_b0, i_b0};
            default:   ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rgb   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) r_rgb <= w_rgb;
        end
    end

    assign o_rgb   = r_rgb;
    assign o_valid = r_valid;
endmodule

// File: rtl/cam_capture_param.sv
// DVP byte-stream capture: frames gated at vsync fall, two bytes per pixel,
// optional decimation, linear write addresses, sticky line/overflow flags.
module cam_capture_param
    import cam_pkg::*;
#(
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int ADDR_W = 19,
    parameter int FCNT_W = 8
) (
    input  logic              ipclk,
    input  logic              ireset_n,
    input  logic              ivsync,
    input  logic              ihref,
    input  logic [7:0]        idata,
    input  logic              ienable,
    input  logic [1:0]        imode,
    input  logic [1:0]        idecim,
    output logic              owr_en,
    output logic [ADDR_W-1:0] oaddr,
    output logic [23:0]       odata_out,
    output logic              oframe_start,
    output logic              oframe_done,
    output logic [FCNT_W-1:0] oframe_cnt,
    output logic              oline_err,
    output logic              oovf
);
    localparam int CW  = 16;
    // One spare address bit so "one past the last pixel" never aliases to 0.
    localparam int AW1 = ADDR_W + 1;
    localparam logic [AW1-1:0] MAX_D1 = AW1'(H_RES * V_RES - 1);
    localparam logic [AW1-1:0] MAX_D2 = AW1'((H_RES >> 1) * (V_RES >> 1) - 1);
    localparam logic [AW1-1:0] MAX_D4 = AW1'((H_RES >> 2) * (V_RES >> 2) - 1);

    logic              r_vsync, r_href, r_vsync_d, r_href_d;
    logic [7:0]        r_data;
    cap_state_t        r_state, w_state_next;
    pix_fmt_t          r_fmt;
    decim_t            r_decim;
    logic              r_phase;
    logic [7:0]        r_b0;
    logic [CW-1:0]     r_x, r_y, w_mask;
    logic [AW1-1:0]    r_addr, r_max, w_max_new;
    logic [ADDR_W-1:0] r_addr_out;
    logic              r_frame_start, r_frame_done, r_line_err, r_ovf;
    logic [FCNT_W-1:0] r_frame_cnt;
    logic              w_vs_fall, w_vs_rise, w_href_rise, w_href_fall;
    logic              w_start, w_done, w_byte, w_second, w_kept, w_in_range, w_wr;
    logic              w_cv_valid;
    logic [23:0]       w_cv_rgb;

    always_ff @(posedge ipclk or negedge ireset_n) begin
        if (!ireset_n) begin
            r_vsync   <= 1'b0;
            r_href    <= 1'b0;
            r_data    <= '0;
            r_vsync_d <= 1'b0;
            r_href_d  <= 1'b0;
        end else begin
            r_vsync   <= ivsync;
            r_href    <= ihref;
            r_data    <= idata;
            r_vsync_d <= r_vsync;
            r_href_d  <= r_href;
        end
    end

    assign w_vs_fall   = r_vsync_d & ~r_vsync;
    assign w_vs_rise   = ~r_vsync_d & r_vsync;
    assign w_href_rise = ~r_href_d & r_href;
    assign w_href_fall = r_href_d & ~r_href;

    always_ff @(posedge ipclk or negedge ireset_n) begin
        if (!ireset_n) r_state <= WAIT_VS;
        else           r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            WAIT_VS: if (w_vs_fall && ienable) begin
                w_state_next = ACTIVE;
                w_start      = 1'b1;
            end
            ACTIVE: if (w_vs_rise) begin
                w_state_next = WAIT_VS;
                w_done       = 1'b1;
            end
            default: w_state_next = WAIT_VS;
        endcase
    end

    always_comb begin
        w_mask = '0;
        case (r_decim)
            DEC_2:   w_mask = CW'(1);
            DEC_4:   w_mask = CW'(3);
            default: w_mask = '0;
        endcase
    end

    always_comb begin
        w_max_new = MAX_D1;
        case (decode_decim(idecim))
            DEC_2:   w_max_new = MAX_D2;
            DEC_4:   w_max_new = MAX_D4;
            default: w_max_new = MAX_D1;
        endcase
    end

    // A byte on the href rising edge always starts a new pixel.
    assign w_byte     = (r_state == ACTIVE) & r_href;
    assign w_second   = w_byte & ~w_href_rise & r_phase;
    assign w_kept     = w_second && ((r_x & w_mask) == '0) && ((r_y & w_mask) == '0);
    assign w_in_range = (r_addr <= r_max);
    assign w_wr       = w_kept & w_in_range;

    always_ff @(posedge ipclk or negedge ireset_n) begin
        if (!ireset_n) begin
            r_fmt         <= PF_RGB565;
            r_decim       <= DEC_1;
            r_phase       <= 1'b0;
            r_b0          <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_addr        <= '0;
            r_max         <= '0;
            r_addr_out    <= '0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_cnt   <= '0;
            r_line_err    <= 1'b0;
            r_ovf         <= 1'b0;
        end else begin
            r_frame_start <= w_start;
            r_frame_done  <= w_done;
            if (w_done) r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
            if (w_wr)   r_addr_out  <= r_addr[ADDR_W-1:0];
            if (w_start) begin
                r_fmt      <= decode_fmt(imode);
                r_decim    <= decode_decim(idecim);
                r_max      <= w_max_new;
                r_addr     <= '0;
                r_x        <= '0;
                r_y        <= '0;
                r_phase    <= 1'b0;
                r_line_err <= 1'b0;
                r_ovf      <= 1'b0;
            end else if (r_state == ACTIVE) begin
                if (w_byte) begin
                    if (w_href_rise || !r_phase) begin
                        r_b0    <= r_data;
                        r_phase <= 1'b1;
                        if (w_href_rise) r_x <= '0;
                    end else begin
                        r_phase <= 1'b0;
                        r_x     <= r_x + CW'(1);
                    end
                end
                // Any dangling first byte is simply dropped here.
                if (w_href_fall) begin
                    r_phase <= 1'b0;
                    r_y     <= r_y + CW'(1);
                    if (r_phase || (r_x != CW'(H_RES))) r_line_err <= 1'b1;
                end
                if (w_wr) r_addr <= r_addr + AW1'(1);
                if (w_kept && !w_in_range) r_ovf <= 1'b1;
            end
        end
    end

    cam_pix_convert u_conv (
        .i_clk   (ipclk),
        .i_rst_n (ireset_n),
        .i_fmt   (r_fmt),
        .i_b0    (r_b0),
        .i_b1    (r_data),
        .i_valid (w_wr),
        .o_rgb   (w_cv_rgb),
        .o_valid (w_cv_valid)
    );

    assign owr_en       = w_cv_valid;
    assign oaddr        = r_addr_out;
    assign odata_out    = w_cv_rgb;
    assign oframe_start = r_frame_start;
    assign oframe_done  = r_frame_done;
    assign oframe_cnt   = r_frame_cnt;
    assign oline_err    = r_line_err;
    assign oovf         = r_ovf;
endmodule

// File: tb/tb_cam_capture_param.sv
// Self-checking bench for cam_capture_param on a 4x4 frame with a frame-level reference model.
module tb_cam_capture_param;
    localparam int H  = 4;
    localparam int V  = 4;
    localparam int AW = 4;
    localparam int FW = 8;

    logic          ipclk = 1'b0;
    logic          ireset_n, ivsync, ihref, ienable;
    logic [7:0]    idata;
    logic [1:0]    imode, idecim;
    logic          owr_en, oframe_start, oframe_done, oline_err, oovf;
    logic [AW-1:0] oaddr;
    logic [23:0]   odata_out;
    logic [FW-1:0] oframe_cnt;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t  got_q[$];
    wr_t  exp_q[$];
    int   cyc = 0;
    int   n_start = 0;
    int   n_done = 0;
    int   n_pass = 0;
    int   n_total = 0;
    logic [7:0] fb[16][32];
    int   flen[16];
    int   p1cyc[16][16];
    int   nlines;
    int   exp_cnt = 0;
    bit   exp_err = 0;
    bit   exp_ovf = 0;
    int   fd;

    cam_capture_param #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .FCNT_W(FW)) dut (
        .ipclk        (ipclk),
        .ireset_n     (ireset_n),
        .ivsync       (ivsync),
        .ihref        (ihref),
        .idata        (idata),
        .ienable      (ienable),
        .imode        (imode),
        .idecim       (idecim),
        .owr_en       (owr_en),
        .oaddr        (oaddr),
        .odata_out    (odata_out),
        .oframe_start (oframe_start),
        .oframe_done  (oframe_done),
        .oframe_cnt   (oframe_cnt),
        .oline_err    (oline_err),
        .oovf         (oovf)
    );

    always #5 ipclk = ~ipclk;

    always @(posedge ipclk) cyc <= cyc + 1;

    always @(negedge ipclk) begin
        if (owr_en) got_q.push_back('{int'(oaddr), int'(odata_out), cyc});
        if (oframe_start) n_start <= n_start + 1;
        if (oframe_done)  n_done  <= n_done + 1;
    end

    task automatic tick();
        @(posedge ipclk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Pixel formats from their textual definitions, using integer arithmetic.
    function automatic int ref_pix(input int mode, input int b0, input int b1);
        int r, g, b, r5, g6, b5;
        if (mode == 1) begin
            r = (b0 % 16) * 17;
            g = (b1 / 16) * 17;
            b = (b1 % 16) * 17;
        end else if (mode == 2) begin
            r = b0; g = b0; b = b0;
        end else begin
            r5 = b0 / 8;
            g6 = (b0 % 8) * 8 + b1 / 32;
            b5 = b1 % 32;
            r  = r5 * 8 + r5 / 4;
            g  = g6 * 4 + g6 / 16;
            b  = b5 * 8 + b5 / 4;
        end
        return r * 65536 + g * 256 + b;
    endfunction

    task automatic fill(input int nl, input int len);
        nlines = nl;
        for (int y = 0; y < nl; y++) begin
            flen[y] = len;
            for (int i = 0; i < 32; i++) fb[y][i] = 8'($urandom);
        end
    endtask

    task automatic build_model(input int mode, input int dec);
        int d, step, maxa, addr, npix;
        d    = (dec >= 2) ? 2 : dec;
        step = 1 << d;
        maxa = (H / step) * (V / step) - 1;
        addr = 0;
        exp_q.delete();
        exp_err = 0;
        exp_ovf = 0;
        for (int y = 0; y < nlines; y++) begin
            npix = flen[y] / 2;
            if ((flen[y] % 2) != 0 || npix != H) exp_err = 1;
            for (int x = 0; x < npix; x++) begin
                if (x % step == 0 && y % step == 0) begin
                    if (addr <= maxa) begin
                        exp_q.push_back('{addr, ref_pix(mode, int'(fb[y][2*x]), int'(fb[y][2*x+1])),
                                          p1cyc[y][x] + 2});
                        addr++;
                    end else begin
                        exp_ovf = 1;
                    end
                end
            end
        end
    endtask

    task automatic run_frame(input string tag, input int mode, input int dec, input bit en,
                             output int first_data);
        int bw, bs, bd, ng;
        bw = got_q.size();
        bs = n_start;
        bd = n_done;
        imode   = 2'(mode);
        idecim  = 2'(dec);
        ienable = en;
        ivsync  = 1'b1;
        repeat (3) tick();
        ivsync = 1'b0;
        repeat (3) tick();
        if (en) begin
            check({tag, " err_clr"}, int'(oline_err), 0);
            check({tag, " ovf_clr"}, int'(oovf), 0);
        end
        // Control inputs wander mid-frame; the latched settings must hold.
        ienable = 1'($urandom_range(0, 1));
        imode   = 2'($urandom);
        idecim  = 2'($urandom);
        for (int y = 0; y < nlines; y++) begin
            ihref = 1'b1;
            for (int i = 0; i < flen[y]; i++) begin
                idata = fb[y][i];
                if (i % 2 == 1) p1cyc[y][i/2] = cyc;
                tick();
            end
            ihref = 1'b0;
            idata = 8'($urandom);
            repeat (2) tick();
        end
        ivsync = 1'b1;
        repeat (6) tick();
        if (en) begin
            build_model(mode, dec);
            exp_cnt = (exp_cnt + 1) % 256;
        end else begin
            exp_q.delete();
        end
        ng = got_q.size() - bw;
        check({tag, " nwr"}, ng, exp_q.size());
        for (int i = 0; i < ng && i < exp_q.size(); i++) begin
            check($sformatf("%s addr%0d", tag, i), got_q[bw+i].addr, exp_q[i].addr);
            check($sformatf("%s data%0d", tag, i), got_q[bw+i].data, exp_q[i].data);
            check($sformatf("%s lat%0d", tag, i), got_q[bw+i].cyc, exp_q[i].cyc);
        end
        first_data = (ng > 0) ? got_q[bw].data : -1;
        check({tag, " starts"}, n_start - bs, int'(en));
        check({tag, " dones"}, n_done - bd, int'(en));
        check({tag, " fcnt"}, int'(oframe_cnt), exp_cnt);
        check({tag, " line_err"}, int'(oline_err), int'(exp_err));
        check({tag, " ovf"}, int'(oovf), int'(exp_ovf));
        $display("frame %s mode=%0d dec=%0d en=%0d writes=%0d", tag, mode, dec, en, ng);
    endtask

    initial begin
        int bw, nl, lens[7];
        lens = '{8, 8, 8, 6, 7, 9, 10};
        ireset_n = 1'b0;
        ivsync   = 1'b1;
        ihref    = 1'b0;
        idata    = '0;
        ienable  = 1'b0;
        imode    = '0;
        idecim   = '0;
        repeat (3) tick();
        check("rst wr_en", int'(owr_en), 0);
        check("rst addr", int'(oaddr), 0);
        check("rst data", int'(odata_out), 0);
        check("rst start", int'(oframe_start), 0);
        check("rst done", int'(oframe_done), 0);
        check("rst fcnt", int'(oframe_cnt), 0);
        check("rst line_err", int'(oline_err), 0);
        check("rst ovf", int'(oovf), 0);
        ireset_n = 1'b1;
        repeat (2) tick();

        fill(4, 8);
        for (int x = 0; x < H; x++) begin
            fb[0][2*x] = 8'hF8;
            fb[0][2*x+1] = 8'h00;
        end
        run_frame("rgb565", 0, 0, 1, fd);
        check("rgb565 const", fd, 'hFF0000);

        fill(4, 8);
        fb[0][0] = 8'h0A; fb[0][1] = 8'h5F;
        run_frame("rgb444", 1, 0, 1, fd);
        check("rgb444 const", fd, 'hAA55FF);

        fill(4, 8);
        fb[0][0] = 8'h80; fb[0][1] = 8'h33;
        run_frame("yuv", 2, 0, 1, fd);
        check("yuv const", fd, 'h808080);

        fill(4, 8); run_frame("mode3", 3, 0, 1, fd);
        fill(4, 8); run_frame("dec2", 0, 1, 1, fd);
        fill(4, 8); run_frame("dec4", 1, 2, 1, fd);
        fill(4, 8); run_frame("dec3", 2, 3, 1, fd);

        fill(4, 8);
        flen[1] = 7;
        run_frame("odd_line", 0, 0, 1, fd);
        fill(4, 8); run_frame("after_err", 0, 0, 1, fd);
        fill(4, 8); run_frame("disabled", 0, 0, 0, fd);
        fill(5, 8); run_frame("ovf_dec2", 0, 1, 1, fd);
        fill(5, 8); run_frame("ovf", 1, 0, 1, fd);

        // Reset in the middle of a line of an active frame.
        fill(4, 8);
        imode = 2'd0; idecim = 2'd0; ienable = 1'b1;
        repeat (3) tick();
        ivsync = 1'b0;
        repeat (3) tick();
        ihref = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idata = fb[0][i];
            tick();
        end
        ireset_n = 1'b0;
        #1;
        check("midrst wr_en", int'(owr_en), 0);
        check("midrst addr", int'(oaddr), 0);
        check("midrst data", int'(odata_out), 0);
        check("midrst start", int'(oframe_start), 0);
        check("midrst done", int'(oframe_done), 0);
        check("midrst fcnt", int'(oframe_cnt), 0);
        check("midrst line_err", int'(oline_err), 0);
        check("midrst ovf", int'(oovf), 0);
        bw = got_q.size();
        repeat (3) tick();
        ihref = 1'b0;
        ivsync = 1'b1;
        ireset_n = 1'b1;
        exp_cnt = 0; exp_err = 0; exp_ovf = 0;
        repeat (3) tick();
        check("midrst no_wr", got_q.size() - bw, 0);
        fill(4, 8); run_frame("post_rst", 0, 0, 1, fd);

        for (int f = 0; f < 8; f++) begin
            nl = $urandom_range(2, 6);
            fill(nl, 8);
            for (int y = 0; y < nl; y++) flen[y] = lens[$urandom_range(0, 6)];
            run_frame($sformatf("rand%0d", f), $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 4) != 0), fd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
